seven_event_monitor: RTL and testbench

Downstream consumer of the three-input Moore sequence detector's decoded outputs z1/z2/z3. Converts each output's rising edge into an event, keeps a saturating occurrence count per output, and queues 2-bit event codes in a small FIFO. A host drains the FIFO over a valid/ready handshake. The block sits between the detector and the lab board's display/readout logic and has no influence on the detector's state.

---
 rtl/seven_event_monitor.sv | 140 ++++++++++++++
 tb/tb_seven_event_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_event_monitor.sv
// seven_event_monitor
// Turns the rising edges of the detector outputs z1/z2/z3 into events. For
// each output it keeps a saturating occurrence count, and it queues 2-bit
// event codes in a small circular FIFO that a host drains over a
// valid/ready handshake. It only observes the detector and never feeds back.
module seven_event_monitor #(
  parameter int unsigned CW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     z1,
  input  logic                     z2,
  input  logic                     z3,
  input  logic                     clear,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [1:0]               ev_code,
  output logic [$clog2(DEPTH):0]   ev_level,
  output logic [CW-1:0]            cnt1,
  output logic [CW-1:0]            cnt2,
  output logic [CW-1:0]            cnt3,
  output logic                     overflow,
  output logic                     multi_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  // Previous-cycle samples of z1..z3, indexed [0]=z1 .. [2]=z3
  logic [2:0]    z_q;
  logic [2:0]    z_now;
  logic [2:0]    rise;

  // FIFO storage and bookkeeping
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  // Per-cycle control decoded from the rises and the handshake
  logic          any_rise;
  logic          multi_rise;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          drop;
  logic [1:0]    push_code;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                            input logic          en);
    if (en && (v != '1)) begin
      return v + CW'(1);
    end
    return v;
  endfunction

  assign z_now = {z3, z2, z1};

  // Edge detection, priority encoding and FIFO handshake decode
  always_comb begin
    rise       = z_now & ~z_q;
    any_rise   = |rise;
    multi_rise = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    full       = (level == LW'(DEPTH));
    ev_valid   = (level != '0);
    pop        = ev_valid & ev_ready & ~clear;
    // Rises in a clear cycle are discarded entirely.
    push_req   = any_rise & ~clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok    = push_req & (~full | pop);
    drop       = push_req & full & ~pop;
    push_code  = 2'b11;
    if (rise[0]) begin
      push_code = 2'b01;
    end else if (rise[1]) begin
      push_code = 2'b10;
    end
    ev_code    = ev_valid ? mem[rd_ptr] : 2'b00;
    ev_level   = level;
  end

  // Edge-detect history, counters, sticky flags and FIFO pointers/occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      z_q       <= '0;
      cnt1      <= '0;
      cnt2      <= '0;
      cnt3      <= '0;
      overflow  <= 1'b0;
      multi_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      // History keeps tracking through clear so a held level stays one event.
      z_q <= z_now;
      if (clear) begin
        cnt1      <= '0;
        cnt2      <= '0;
        cnt3      <= '0;
        overflow  <= 1'b0;
        multi_err <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
      end else begin
        cnt1 <= sat_inc(cnt1, rise[0]);
        cnt2 <= sat_inc(cnt2, rise[1]);
        cnt3 <= sat_inc(cnt3, rise[2]);
        if (drop) begin
          overflow <= 1'b1;
        end
        if (multi_rise) begin
          multi_err <= 1'b1;
        end
        if (push_ok) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        unique case ({push_ok, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // FIFO entry storage; contents are only visible through the occupancy gate
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_code;
    end
  end

endmodule

// File: tb/tb_seven_event_monitor.sv
// Directed self-checking bench for seven_event_monitor. A default instance
// (CW=8, DEPTH=4) covers queueing, overflow, clear and reset; a CW=2
// instance covers multi-rise and counter saturation.
module tb_seven_event_monitor;

  logic       clk = 1'b0;
  logic       reset, clear;
  logic       z1, z2, z3, ev_ready;
  logic       ev_valid, overflow, multi_err;
  logic [1:0] ev_code;
  logic [2:0] ev_level;
  logic [7:0] cnt1, cnt2, cnt3;

  logic       b_z1, b_z2, b_z3, b_ready;
  logic       b_valid, b_overflow, b_multi_err;
  logic [1:0] b_code;
  logic [2:0] b_level;
  logic [1:0] b_cnt1, b_cnt2, b_cnt3;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  seven_event_monitor #(.CW(8), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .z1(z1), .z2(z2), .z3(z3), .clear(clear),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_level(ev_level), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .overflow(overflow), .multi_err(multi_err)
  );

  seven_event_monitor #(.CW(2), .DEPTH(4)) u_dut_sat (
    .clk(clk), .reset(reset), .z1(b_z1), .z2(b_z2), .z3(b_z3), .clear(clear),
    .ev_ready(b_ready), .ev_valid(b_valid), .ev_code(b_code),
    .ev_level(b_level), .cnt1(b_cnt1), .cnt2(b_cnt2), .cnt3(b_cnt3),
    .overflow(b_overflow), .multi_err(b_multi_err)
  );

  // One clock: inputs set before the call are sampled at this edge, and
  // outputs are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    z1 = 0; z2 = 0; z3 = 0; ev_ready = 0; clear = 0;
    b_z1 = 0; b_z2 = 0; b_z3 = 0; b_ready = 0;
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ev_valid); end
    checks++; if (ev_code !== 2'b00) begin errors++; $display("FAIL reset_code got %0b exp 00", ev_code); end
    checks++; if (ev_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", ev_level); end
    checks++; if ({cnt1, cnt2, cnt3} !== 24'd0) begin errors++; $display("FAIL reset_cnts got %0d/%0d/%0d exp 0/0/0", cnt1, cnt2, cnt3); end
    checks++; if ({overflow, multi_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %0b%0b exp 00", overflow, multi_err); end
  endtask

  task automatic test_single_events();
    do_reset();
    z1 = 1; step();
    checks++; if (ev_valid !== 1'b1 || ev_code !== 2'b01) begin errors++; $display("FAIL single_latency got v=%0b c=%0b exp v=1 c=01", ev_valid, ev_code); end
    z1 = 0; step(); step();
    z3 = 1; step();
    z3 = 0; step();
    checks++; if (cnt1 !== 8'd1 || cnt3 !== 8'd1 || cnt2 !== 8'd0) begin errors++; $display("FAIL single_cnts got %0d/%0d/%0d exp 1/0/1", cnt1, cnt2, cnt3); end
    checks++; if (ev_level !== 3'd2) begin errors++; $display("FAIL single_level got %0d exp 2", ev_level); end
    checks++; if (ev_code !== 2'b01) begin errors++; $display("FAIL single_head got %0b exp 01", ev_code); end
    checks++; if (multi_err !== 1'b0) begin errors++; $display("FAIL single_multi got %0b exp 0", multi_err); end
    ev_ready = 1; step(); ev_ready = 0;
    checks++; if (ev_code !== 2'b11 || ev_level !== 3'd1) begin errors++; $display("FAIL single_pop got c=%0b l=%0d exp c=11 l=1", ev_code, ev_level); end
    ev_ready = 1; step(); ev_ready = 0;
    checks++; if (ev_valid !== 1'b0 || ev_code !== 2'b00 || ev_level !== 3'd0) begin errors++; $display("FAIL single_empty got v=%0b c=%0b l=%0d exp v=0 c=00 l=0", ev_valid, ev_code, ev_level); end
  endtask

  task automatic test_level_held();
    do_reset();
    z2 = 1;
    for (int i = 0; i < 5; i++) step();
    z2 = 0; step();
    checks++; if (cnt2 !== 8'd1) begin errors++; $display("FAIL held_cnt2 got %0d exp 1", cnt2); end
    checks++; if (ev_level !== 3'd1 || ev_code !== 2'b10) begin errors++; $display("FAIL held_fifo got l=%0d c=%0b exp l=1 c=10", ev_level, ev_code); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin z1 = 1; step(); z1 = 0; step(); end
    checks++; if (ev_level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_noflag got l=%0d o=%0b exp l=4 o=0", ev_level, overflow); end
    z1 = 1; step(); z1 = 0; step();
    checks++; if (ev_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", ev_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    checks++; if (cnt1 !== 8'd5) begin errors++; $display("FAIL ovf_cnt1 got %0d exp 5", cnt1); end
    ev_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ev_valid !== 1'b1 || ev_code !== 2'b01) begin errors++; $display("FAIL ovf_drain%0d got v=%0b c=%0b exp v=1 c=01", i, ev_valid, ev_code); end
      step();
    end
    ev_ready = 0;
    checks++; if (ev_valid !== 1'b0 || ev_level !== 3'd0) begin errors++; $display("FAIL ovf_drained got v=%0b l=%0d exp v=0 l=0", ev_valid, ev_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
  endtask

  task automatic test_full_pop();
    logic [1:0] exp_codes [4];
    exp_codes[0] = 2'b01; exp_codes[1] = 2'b01; exp_codes[2] = 2'b01; exp_codes[3] = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) begin z1 = 1; step(); z1 = 0; step(); end
    z2 = 1; ev_ready = 1; step(); z2 = 0;
    checks++; if (ev_level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d exp 4", ev_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %0b exp 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ev_code !== exp_codes[i]) begin errors++; $display("FAIL fullpop_drain%0d got %0b exp %0b", i, ev_code, exp_codes[i]); end
      step();
    end
    ev_ready = 0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %0b exp 0", ev_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // ready while empty must not pop the entry being pushed
    z1 = 1; ev_ready = 1; step(); ev_ready = 0;
    checks++; if (ev_level !== 3'd1 || ev_code !== 2'b01) begin errors++; $display("FAIL b2b_empty_ready got l=%0d c=%0b exp l=1 c=01", ev_level, ev_code); end
    z1 = 0; z2 = 1; step();
    z2 = 0; z3 = 1; step();
    z3 = 0; step();
    checks++; if (ev_level !== 3'd3) begin errors++; $display("FAIL b2b_level got %0d exp 3", ev_level); end
    checks++; if ({cnt1, cnt2, cnt3} !== {8'd1, 8'd1, 8'd1}) begin errors++; $display("FAIL b2b_cnts got %0d/%0d/%0d exp 1/1/1", cnt1, cnt2, cnt3); end
    ev_ready = 1;
    checks++; if (ev_code !== 2'b01) begin errors++; $display("FAIL b2b_head0 got %0b exp 01", ev_code); end
    step();
    checks++; if (ev_code !== 2'b10) begin errors++; $display("FAIL b2b_head1 got %0b exp 10", ev_code); end
    step();
    checks++; if (ev_code !== 2'b11) begin errors++; $display("FAIL b2b_head2 got %0b exp 11", ev_code); end
    step();
    ev_ready = 0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", ev_valid); end
  endtask

  task automatic test_multi_saturate();
    do_reset();
    b_z1 = 1; b_z3 = 1; step(); b_z1 = 0; b_z3 = 0; step();
    checks++; if (b_level !== 3'd1 || b_code !== 2'b01) begin errors++; $display("FAIL multi_push got l=%0d c=%0b exp l=1 c=01", b_level, b_code); end
    checks++; if (b_cnt1 !== 2'd1 || b_cnt2 !== 2'd0 || b_cnt3 !== 2'd1) begin errors++; $display("FAIL multi_cnts got %0d/%0d/%0d exp 1/0/1", b_cnt1, b_cnt2, b_cnt3); end
    checks++; if (b_multi_err !== 1'b1) begin errors++; $display("FAIL multi_flag got %0b exp 1", b_multi_err); end
    for (int i = 0; i < 2; i++) begin b_z1 = 1; step(); b_z1 = 0; step(); end
    checks++; if (b_cnt1 !== 2'd3) begin errors++; $display("FAIL sat_reach got %0d exp 3", b_cnt1); end
    for (int i = 0; i < 2; i++) begin b_z1 = 1; step(); b_z1 = 0; step(); end
    checks++; if (b_cnt1 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", b_cnt1); end
    checks++; if (b_cnt3 !== 2'd1) begin errors++; $display("FAIL sat_cnt3 got %0d exp 1", b_cnt3); end
    checks++; if (b_level !== 3'd4 || b_overflow !== 1'b1) begin errors++; $display("FAIL sat_fifo got l=%0d o=%0b exp l=4 o=1", b_level, b_overflow); end
  endtask

  // Queue three entries with multi_err set: {z1,z2} together, then z3, then z1.
  task automatic load_three();
    do_reset();
    z1 = 1; z2 = 1; step(); z1 = 0; z2 = 0; step();
    z3 = 1; step(); z3 = 0; step();
    z1 = 1; step(); z1 = 0; step();
  endtask

  task automatic test_clear_reset();
    load_three();
    checks++; if (ev_level !== 3'd3 || multi_err !== 1'b1 || cnt1 !== 8'd2) begin errors++; $display("FAIL clr_setup got l=%0d m=%0b c1=%0d exp l=3 m=1 c1=2", ev_level, multi_err, cnt1); end
    clear = 1; z1 = 1; ev_ready = 1; step(); clear = 0; ev_ready = 0;
    checks++; if ({cnt1, cnt2, cnt3} !== 24'd0) begin errors++; $display("FAIL clr_cnts got %0d/%0d/%0d exp 0/0/0", cnt1, cnt2, cnt3); end
    checks++; if (ev_valid !== 1'b0 || ev_level !== 3'd0 || ev_code !== 2'b00) begin errors++; $display("FAIL clr_fifo got v=%0b l=%0d c=%0b exp v=0 l=0 c=00", ev_valid, ev_level, ev_code); end
    checks++; if ({overflow, multi_err} !== 2'b00) begin errors++; $display("FAIL clr_flags got %0b%0b exp 00", overflow, multi_err); end
    step();
    checks++; if (cnt1 !== 8'd0 || ev_level !== 3'd0) begin errors++; $display("FAIL clr_held got c1=%0d l=%0d exp c1=0 l=0", cnt1, ev_level); end
    z1 = 0; step();

    load_three();
    reset = 1; clear = 1; z1 = 1; ev_ready = 1; step(); reset = 0; clear = 0; ev_ready = 0;
    checks++; if ({cnt1, cnt2, cnt3} !== 24'd0 || ev_level !== 3'd0 || ev_valid !== 1'b0) begin errors++; $display("FAIL rst_state got c=%0d/%0d/%0d l=%0d v=%0b exp 0/0/0 l=0 v=0", cnt1, cnt2, cnt3, ev_level, ev_valid); end
    checks++; if ({overflow, multi_err} !== 2'b00) begin errors++; $display("FAIL rst_flags got %0b%0b exp 00", overflow, multi_err); end
    // z1 stays high: with z_q cleared this is a fresh rise
    step();
    checks++; if (cnt1 !== 8'd1 || ev_level !== 3'd1 || ev_code !== 2'b01) begin errors++; $display("FAIL rst_zq got c1=%0d l=%0d c=%0b exp c1=1 l=1 c=01", cnt1, ev_level, ev_code); end
    z1 = 0; step();
  endtask

  initial begin
    test_reset();
    test_single_events();
    test_level_held();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_multi_saturate();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
